led_arbiter: RTL and testbench



---
 rtl/led_arbiter.sv | 115 +++++++++++
 tb/tb_led_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/led_arbiter.sv
// led_arbiter: round-robin sharing of one LED between N_REQ requesters, timed on/off intervals.
// Optional LED_ARB_ABORT_EN adds an abort input that cuts an ON interval short.
module led_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 100_000_000,
  parameter int GAP_UNITS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DUR_W-1:0]     dur,
`ifdef LED_ARB_ABORT_EN
  input  logic                       abort,
`endif
  output logic [N_REQ-1:0]           ack,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       led
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = $clog2(GAP_UNITS + 1);
  localparam int UW = DUR_W > GW ? DUR_W : GW;
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [UW-1:0]     unit_q, unit_d;
  logic [IW-1:0]     rr_q, rr_d, gid_q, gid_d, sel, idx;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              led_q, led_d, found, wrap, abort_w;
  logic [DUR_W-1:0]  sel_dur;
`ifdef LED_ARB_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif
  // First asserted request at or after rr_q, wrapping modulo N_REQ
  always_comb begin
    sel     = '0;
    idx     = '0;
    found   = 1'b0;
    sel_dur = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(rr_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++)
      if (IW'(i) == sel) sel_dur = dur[i*DUR_W +: DUR_W];
  end
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    unit_d  = unit_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    ack_d   = '0;
    led_d   = led_q;
    wrap    = tick_q == TW'(TICK_DIV - 1);
    if (state_q == IDLE) begin
      if (found) begin
        ack_d[sel] = 1'b1;
        gid_d      = sel;
        unit_d     = UW'(sel_dur);
        rr_d       = sel == IW'(N_REQ - 1) ? '0 : sel + 1'b1;
        tick_d     = '0;
        if (sel_dur != '0) begin
          led_d   = 1'b1;
          state_d = ON;
        end
      end
    end else if (state_q == ON && abort_w) begin
      led_d   = 1'b0;
      state_d = GAP;
      unit_d  = UW'(GAP_UNITS);
      tick_d  = '0;
    end else begin
      tick_d = wrap ? '0 : tick_q + 1'b1;
      if (wrap) begin
        unit_d = unit_q - 1'b1;
        if (unit_q == UW'(1)) begin
          led_d   = 1'b0;
          state_d = state_q == ON ? GAP : IDLE;
          unit_d  = state_q == ON ? UW'(GAP_UNITS) : '0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      unit_q  <= '0;
      rr_q    <= '0;
      gid_q   <= '0;
      ack_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      unit_q  <= unit_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      led_q   <= led_d;
    end
  end
  assign ack      = ack_q;
  assign grant_id = gid_q;
  assign busy     = state_q != IDLE;
  assign led      = led_q;
endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: directed checks of led_arbiter with TICK_DIV=4, GAP_UNITS=1, N_REQ=4, DUR_W=8.
module tb_led_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] dur = '0;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy, led;
`ifdef LED_ARB_ABORT_EN
  logic        abort = 1'b0;
`endif
  int checks = 0, failures = 0, cyc = 0, prev = 0, hi, gap, acks;
  led_arbiter #(.N_REQ(4), .DUR_W(8), .TICK_DIV(4), .GAP_UNITS(1)) dut (
    .clk(clk), .rst(rst), .req(req), .dur(dur),
`ifdef LED_ARB_ABORT_EN
    .abort(abort),
`endif
    .ack(ack), .grant_id(grant_id), .busy(busy), .led(led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic wait_ack();
    int n = 0;
    while (ack == '0 && n < 60) begin
      step();
      n++;
    end
    chk("ack_timeout", 32'(ack != '0), 1);
  endtask
  task automatic count_hi(output int h, output int a);
    h = 0;
    a = 0;
    while (led && h < 2000) begin
      h++;
      if (ack != '0) a++;
      step();
    end
  endtask
  task automatic count_busy(output int g);
    g = 0;
    while (busy && g < 100) begin
      g++;
      step();
    end
  endtask
  initial begin
    do_reset();
    chk("rst_led", 32'(led), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    // single grant
    dur = 32'h0000_0003;
    req = 4'b0001;
    wait_ack();
    chk("sg_ack", 32'(ack), 32'h1);
    chk("sg_gid", 32'(grant_id), 0);
    chk("sg_busy", 32'(busy), 1);
    req = '0;
    count_hi(hi, acks);
    chk("sg_hi", 32'(hi), 12);
    chk("sg_ack_len", 32'(acks), 1);
    count_busy(gap);
    chk("sg_gap", 32'(gap), 4);
    chk("sg_led_off", 32'(led), 0);
    // round-robin
    do_reset();
    dur = 32'h0101_0101;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack();
      chk("rr_gid", 32'(grant_id), 32'(g % 4));
      chk("rr_ack", 32'(ack), 32'(1 << (g % 4)));
      if (g > 0) chk("rr_spacing", 32'(cyc - prev), 9);
      prev = cyc;
      count_hi(hi, acks);
      chk("rr_hi", 32'(hi), 4);
    end
    req = '0;
    count_busy(gap);
    // zero duration followed by a normal grant
    do_reset();
    dur = 32'h0200_0000;
    req = 4'b1100;
    wait_ack();
    chk("zd_ack2", 32'(ack), 32'h4);
    chk("zd_led0", 32'(led), 0);
    chk("zd_busy0", 32'(busy), 0);
    req = 4'b1000;
    step();
    chk("zd_ack3", 32'(ack), 32'h8);
    chk("zd_gid3", 32'(grant_id), 3);
    req = '0;
    count_hi(hi, acks);
    chk("zd_hi", 32'(hi), 8);
    count_busy(gap);
    // reset in the middle of ON
    dur = 32'h0000_0500;
    req = 4'b0010;
    wait_ack();
    chk("rm_gid", 32'(grant_id), 1);
    req = '0;
    for (int i = 0; i < 5; i++) step();
    chk("rm_led_on", 32'(led), 1);
    rst = 1'b1;
    step();
    chk("rm_led", 32'(led), 0);
    chk("rm_busy", 32'(busy), 0);
    rst = 1'b0;
    dur = 32'h0001_0100;
    req = 4'b0110;
    wait_ack();
    chk("rm_next_gid", 32'(grant_id), 1);
    req = '0;
    count_hi(hi, acks);
    count_busy(gap);
    // maximum duration
    dur = 32'h0000_00FF;
    req = 4'b0001;
    wait_ack();
    chk("mx_gid", 32'(grant_id), 0);
    req = '0;
    count_hi(hi, acks);
    chk("mx_hi", 32'(hi), 1020);
    count_busy(gap);
    chk("mx_gap", 32'(gap), 4);
`ifdef LED_ARB_ABORT_EN
    do_reset();
    dur = 32'h0000_010A;
    req = 4'b0001;
    wait_ack();
    req = '0;
    step();
    step();
    chk("ab_led_on", 32'(led), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_led", 32'(led), 0);
    chk("ab_busy", 32'(busy), 1);
    count_busy(gap);
    chk("ab_gap", 32'(gap), 4);
    req = 4'b0010;
    wait_ack();
    chk("ab_next_gid", 32'(grant_id), 1);
    req = '0;
    count_hi(hi, acks);
    chk("ab_next_hi", 32'(hi), 4);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
